coke_vend_fsm: RTL and testbench
================================

// Module: coke_vend_fsm
// PURPOSE
//  Coin-operated drink vending controller: accepts one coin code per clock, accumulates credit,
//  pulses a dispense strobe when credit reaches the price, returns change/refund in 5-cent units.
//  Sits between the coin acceptor front-end and the dispenser/change-hopper drivers.
// PARAMETERS
//  PRICE_UNITS  3  drink price in 5-cent units (3 = 15c); legal range 1..4
//  STOCK_INIT   8  initial drink count (used only with STOCK_TRACK_EN)
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous active-low reset
//  m       in   [0:1]  coin code this cycle, m[0]=MSB, value in 5c units: 00 none, 01 5c, 10 10c, 11 15c
//  n       in   1      cancel request (refund held credit)
//  y       out  1      dispense strobe, one-cycle pulse, registered
//  ch      out  [0:1]  change/refund amount, 5c units (ch[0]=MSB), valid for one cycle, else 00
//  empty   out  1      stock exhausted (only with STOCK_TRACK_EN)
// BEHAVIOUR
//  - Reset (async assert, sync release): credit=0, y=0, ch=00, stock=STOCK_INIT.
//  - State = credit register, 0..PRICE_UNITS-1 units (credit never rests at >= price).
//  - All outputs registered; response appears on the cycle after the sampled input (latency 1).
//  - Each cycle, priority order:
//    1. n=1: ch<=credit, credit<=0, y<=0; any coin on m that cycle is rejected (not credited).
//    2. n=0, m!=00: sum=credit+m (3-bit). If sum>=PRICE_UNITS: y<=1, ch<=sum-PRICE_UNITS,
//       credit<=0. Else credit<=sum, y<=0, ch<=00.
//    3. n=0, m=00: hold credit, y<=0, ch<=00.
//  - Change never exceeds 2 units for PRICE_UNITS>=1; refund never exceeds PRICE_UNITS-1 (fits 2 bits).
//  - Cancel with zero credit: ch=00, no other effect.
//  - Back-to-back coins every cycle allowed; a vend cycle and a new coin next cycle are independent.
//  - Reset mid-transaction discards credit with no refund and no dispense pulse.
// CONFIGURATION
//  - STOCK_TRACK_EN defined: stock counter (width clog2(STOCK_INIT+1)) decrements on each y pulse;
//    empty=1 when stock==0. While empty, every coin is rejected: ch<=m next cycle, credit unchanged,
//    y never asserts; cancel still refunds held credit. Stock reloads only on reset.
//  - STOCK_TRACK_EN undefined: no empty port, no counter, unlimited stock.
// STRUCTURE
//  - Package coke_vend_pkg: coin code constants (COIN_NONE/5/10/15), unit width localparam,
//    credit-state typedef.
//  - One sub-module natural: coke_credit_calc (combinational sum/compare/change math); top holds
//    registers, cancel priority and optional stock counter.
// TESTING
//  - Reset: hold rst_n=0 with m=10 -> y=0, ch=00, credit 0; release, idle -> outputs stay 0.
//  - Exact pay: m=01,01,01 on consecutive cycles -> y=1 one cycle after third coin, ch=00.
//  - Overpay: m=10 then m=10 -> y=1, ch=01 (5c change) one cycle after second coin.
//  - Cancel: m=10, then n=1 -> y=0, ch=10; next cycle ch=00, credit 0.
//  - Cancel+coin same cycle: credit 5c, n=1 with m=10 -> ch=01, y=0, 10c coin not credited.
//  - STOCK_TRACK_EN, STOCK_INIT=1: vend once -> empty=1; then m=10 -> ch=10, y=0.

Source files
------------

// File: rtl/coke_vend_pkg.sv
// Shared types and constants for the coke vending controller.
// Optional feature macro used by the design: STOCK_TRACK_EN.
package coke_vend_pkg;

    // Money is counted in 5-cent units; two bits cover every coin, credit and change value.
    localparam int unsigned UNIT_W = 2;

    typedef logic [UNIT_W-1:0] credit_t;

    localparam credit_t COIN_NONE = 2'b00;
    localparam credit_t COIN_5    = 2'b01;
    localparam credit_t COIN_10   = 2'b10;
    localparam credit_t COIN_15   = 2'b11;

endpackage

// File: rtl/coke_vend_fsm_if.sv
// Coin/dispense bus between the coin acceptor side and the vending controller.
// The empty flag exists only when STOCK_TRACK_EN is defined.
interface coke_vend_fsm_if;

    logic [0:1] m;      // coin code, m[0] is the MSB
    logic       n;      // cancel request
    logic       y;      // dispense strobe
    logic [0:1] ch;     // change/refund, ch[0] is the MSB
`ifdef STOCK_TRACK_EN
    logic       empty;  // stock exhausted

    modport master (output m, output n, input y, input ch, input empty);
    modport slave  (input m, input n, output y, output ch, output empty);
`else
    modport master (output m, output n, input y, input ch);
    modport slave  (input m, input n, output y, output ch);
`endif

endinterface

// File: rtl/coke_credit_calc.sv
// Combinational credit arithmetic: adds a coin to the held credit, decides whether the
// price is reached and works out the change.
module coke_credit_calc
    import coke_vend_pkg::*;
#(
    parameter int unsigned PRICE_UNITS = 3
) (
    input  credit_t i_credit,
    input  credit_t i_coin,
    output logic    o_vend,
    output credit_t o_change,
    output credit_t o_credit
);

    localparam logic [2:0] PRICE_W3 = 3'(PRICE_UNITS);
    localparam credit_t    PRICE_LO = 2'(PRICE_UNITS);

    logic [2:0] w_sum;

    // Sum, price compare and change. Change is at most 2 units, so a mod-4 subtraction
    // of the low bits is exact (this also covers PRICE_UNITS = 4, whose low bits are 0).
    always_comb begin
        w_sum    = {1'b0, i_credit} + {1'b0, i_coin};
        o_vend   = (w_sum >= PRICE_W3);
        o_change = o_vend ? (w_sum[1:0] - PRICE_LO) : COIN_NONE;
        o_credit = o_vend ? COIN_NONE : w_sum[1:0];
    end

endmodule

// File: rtl/coke_vend_fsm.sv
// Coin-operated drink vending controller. Credit register is the state; dispense strobe and
// change are registered and respond one cycle after the sampled coin/cancel.
// Optional stock tracking with an empty flag is enabled by defining STOCK_TRACK_EN.
module coke_vend_fsm
    import coke_vend_pkg::*;
#(
    parameter int unsigned PRICE_UNITS = 3
`ifdef STOCK_TRACK_EN
    ,
    parameter int unsigned STOCK_INIT  = 8
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    coke_vend_fsm_if.slave      bus
);

    credit_t r_credit;
    logic    r_y;
    credit_t r_ch;

    credit_t w_coin;
    logic    w_vend;
    credit_t w_change;
    credit_t w_credit_nxt;

    assign w_coin = bus.m;

    coke_credit_calc #(
        .PRICE_UNITS (PRICE_UNITS)
    ) u_calc (
        .i_credit (r_credit),
        .i_coin   (w_coin),
        .o_vend   (w_vend),
        .o_change (w_change),
        .o_credit (w_credit_nxt)
    );

`ifdef STOCK_TRACK_EN
    localparam int unsigned STOCK_W = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;

    logic [STOCK_W-1:0] r_stock;
    logic               w_empty;

    assign w_empty   = (r_stock == '0);
    assign bus.empty = w_empty;

    // Credit/output state machine with stock counter; cancel beats coin, empty rejects coins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit <= COIN_NONE;
            r_y      <= 1'b0;
            r_ch     <= COIN_NONE;
            r_stock  <= STOCK_W'(STOCK_INIT);
        end else if (bus.n) begin
            r_ch     <= r_credit;
            r_credit <= COIN_NONE;
            r_y      <= 1'b0;
        end else if (w_empty) begin
            // Sold out: bounce the coin straight back (COIN_NONE bounces as 00).
            r_ch     <= w_coin;
            r_y      <= 1'b0;
        end else if (w_coin != COIN_NONE) begin
            r_y      <= w_vend;
            r_ch     <= w_change;
            r_credit <= w_credit_nxt;
            if (w_vend) begin
                r_stock <= r_stock - 1'b1;
            end
        end else begin
            r_y      <= 1'b0;
            r_ch     <= COIN_NONE;
        end
    end
`else
    // Credit/output state machine; cancel beats coin, idle holds credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit <= COIN_NONE;
            r_y      <= 1'b0;
            r_ch     <= COIN_NONE;
        end else if (bus.n) begin
            r_ch     <= r_credit;
            r_credit <= COIN_NONE;
            r_y      <= 1'b0;
        end else if (w_coin != COIN_NONE) begin
            r_y      <= w_vend;
            r_ch     <= w_change;
            r_credit <= w_credit_nxt;
        end else begin
            r_y      <= 1'b0;
            r_ch     <= COIN_NONE;
        end
    end
`endif

    assign bus.y  = r_y;
    assign bus.ch = r_ch;

endmodule

// File: tb/tb_coke_vend_fsm.sv
// Self-checking bench for coke_vend_fsm: directed steps, expected outputs queued by a
// behavioural model when each input is driven and compared one cycle later.
module tb_coke_vend_fsm;

    localparam int unsigned PRICE = 3;
`ifdef STOCK_TRACK_EN
    localparam int unsigned STOCK = 1;
`endif

    typedef struct packed {
        logic       y;
        logic [1:0] ch;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    exp_t sb[$];
    int   mcred;
`ifdef STOCK_TRACK_EN
    int   mstock;
`endif

    coke_vend_fsm_if bus_if ();

    coke_vend_fsm #(
        .PRICE_UNITS (PRICE)
`ifdef STOCK_TRACK_EN
        ,
        .STOCK_INIT  (STOCK)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model one cycle of the controller and queue the expected registered outputs.
    task automatic model(input logic [1:0] mi, input logic ni);
        exp_t e;
        int   sum;
        e.y  = 1'b0;
        e.ch = 2'b00;
        if (ni) begin
            e.ch  = 2'(mcred);
            mcred = 0;
`ifdef STOCK_TRACK_EN
        end else if (mstock == 0) begin
            e.ch = mi;
`endif
        end else if (mi != 2'b00) begin
            sum = mcred + int'(mi);
            if (sum >= int'(PRICE)) begin
                e.y   = 1'b1;
                e.ch  = 2'(sum - int'(PRICE));
                mcred = 0;
`ifdef STOCK_TRACK_EN
                mstock--;
`endif
            end else begin
                mcred = sum;
            end
        end
        sb.push_back(e);
    endtask

    task automatic step(input logic [1:0] mi, input logic ni, input string tag);
        exp_t e;
        logic [1:0] got_ch;
        bus_if.m = mi;
        bus_if.n = ni;
        model(mi, ni);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e      = sb.pop_front();
            got_ch = bus_if.ch;
            chk({tag, "_y"}, int'(bus_if.y), int'(e.y));
            chk({tag, "_ch"}, int'(got_ch), int'(e.ch));
`ifdef STOCK_TRACK_EN
            chk({tag, "_empty"}, int'(bus_if.empty), int'(mstock == 0));
`endif
        end
    endtask

    task automatic model_reset();
        mcred = 0;
        sb.delete();
`ifdef STOCK_TRACK_EN
        mstock = int'(STOCK);
`endif
    endtask

    initial begin
        logic [1:0] ch_now;
        model_reset();
        rst_n    = 1'b0;
        bus_if.m = 2'b10;
        bus_if.n = 1'b0;

        // Reset held with a coin present: outputs stay quiet.
        repeat (3) @(posedge clk);
        #1;
        ch_now = bus_if.ch;
        chk("rst_y", int'(bus_if.y), 0);
        chk("rst_ch", int'(ch_now), 0);
`ifdef STOCK_TRACK_EN
        chk("rst_empty", int'(bus_if.empty), 0);
`endif
        bus_if.m = 2'b00;
        rst_n    = 1'b1;
        step(2'b00, 1'b0, "idle0");
        step(2'b00, 1'b1, "idle_cancel");   // proves credit is 0 after reset

        // Exact pay with three 5c coins, then idle.
        step(2'b01, 1'b0, "exact1");
        step(2'b01, 1'b0, "exact2");
        step(2'b01, 1'b0, "exact3");
        step(2'b00, 1'b0, "exact_idle");

        // Overpay: 10c + 10c gives 5c change.
        step(2'b10, 1'b0, "over1");
        step(2'b10, 1'b0, "over2");

        // Cancel refunds 10c, then strobe clears.
        step(2'b10, 1'b0, "cancel_coin");
        step(2'b00, 1'b1, "cancel");
        step(2'b00, 1'b0, "cancel_after");
        step(2'b00, 1'b1, "cancel_zero");

        // Cancel together with a coin: coin rejected, only held 5c refunded.
        step(2'b01, 1'b0, "cc_coin");
        step(2'b10, 1'b1, "cc_cancel");
        step(2'b00, 1'b1, "cc_verify");

        // 15c coin variants and back-to-back vends.
        step(2'b11, 1'b0, "c15_only");
        step(2'b10, 1'b0, "c15_pre10");
        step(2'b11, 1'b0, "c15_ch2");
        step(2'b01, 1'b0, "c15_pre5");
        step(2'b11, 1'b0, "c15_ch1");
        step(2'b11, 1'b0, "b2b_1");
        step(2'b11, 1'b0, "b2b_2");
        step(2'b01, 1'b0, "hold_a");
        step(2'b00, 1'b0, "hold_b");
        step(2'b01, 1'b0, "hold_c");
        step(2'b00, 1'b1, "hold_refund");

        // Reset mid-transaction discards credit without refund or strobe.
        step(2'b10, 1'b0, "mid_coin");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        ch_now = bus_if.ch;
        chk("mid_rst_y", int'(bus_if.y), 0);
        chk("mid_rst_ch", int'(ch_now), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2'b00, 1'b1, "mid_refund");

        // Short pseudo-random run against the model.
        for (int i = 0; i < 40; i++) begin
            step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
